// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache arbiter and future cache controllers:
// FSM state encoding and default bus/counter widths.
package cache_arb_pkg;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;
  localparam int unsigned CW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/cache_arbiter_rr_arb2.sv
// Two-way round-robin selector: combinational one-hot grant, registered
// pointer to the requester granted most recently.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt,
  output logic       last_gnt
);

  logic r_last;

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = r_last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

  // Pointer resets to 1 so requester 0 wins the first contested round.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_last <= 1'b1;
    else if (update && (|req))
      r_last <= gnt[1];
  end

  assign last_gnt = r_last;

endmodule

// File: rtl/cache_arbiter.sv
// Serialises two requesters onto a single cache port, one transaction in
// flight at a time, with read/miss statistics.
module cache_arbiter
  import cache_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic [DW-1:0] c_data,
  output logic [AW-1:0] c_addr,
  output logic          c_wr,
  input  logic          c_state,
  input  logic          c_missrate,
  input  logic [DW-1:0] c_q,
  output logic [CW-1:0] rd_cnt,
  output logic [CW-1:0] miss_cnt
);

  arb_state_e    r_state, w_state_nxt;
  logic [1:0]    w_req, w_gnt;
  logic          w_last, w_upd, w_done;
  logic          r_ack0, r_ack1, r_c_wr;
  logic [DW-1:0] r_rdata0, r_rdata1, r_c_data;
  logic [AW-1:0] r_c_addr;
  logic [CW-1:0] r_rd_cnt, r_miss_cnt;

  assign w_req = {req1, req0};

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (w_req),
    .update   (w_upd),
    .gnt      (w_gnt),
    .last_gnt (w_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_upd       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_upd       = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (c_state) begin
          w_done      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The arbiter pointer equals the owner of the outstanding transaction,
  // so it also routes the completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_c_data   <= '0;
      r_c_addr   <= '0;
      r_c_wr     <= 1'b0;
      r_rd_cnt   <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      if (w_upd) begin
        r_c_wr   <= w_gnt[1] ? wr1    : wr0;
        r_c_addr <= w_gnt[1] ? addr1  : addr0;
        r_c_data <= w_gnt[1] ? wdata1 : wdata0;
      end
      if (w_done) begin
        if (w_last) r_ack1 <= 1'b1;
        else        r_ack0 <= 1'b1;
        if (!r_c_wr) begin
          if (w_last) r_rdata1 <= c_q;
          else        r_rdata0 <= c_q;
          if (!(&r_rd_cnt)) r_rd_cnt <= r_rd_cnt + CW'(1);
          if (c_missrate && !(&r_miss_cnt)) r_miss_cnt <= r_miss_cnt + CW'(1);
        end
      end
    end
  end

  assign ack0     = r_ack0;
  assign ack1     = r_ack1;
  assign rdata0   = r_rdata0;
  assign rdata1   = r_rdata1;
  assign c_data   = r_c_data;
  assign c_addr   = r_c_addr;
  assign c_wr     = r_c_wr;
  assign rd_cnt   = r_rd_cnt;
  assign miss_cnt = r_miss_cnt;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed and randomized bench for cache_arbiter; a transaction-level model
// predicts winner, ack timing, read data and saturating statistics.
module tb_cache_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    t_req = '0;
  logic [1:0]    t_wr = '0;
  logic [AW-1:0] t_addr [2];
  logic [DW-1:0] t_wd [2];
  logic          c_state = 1'b1;
  logic          c_missrate = 1'b0;
  logic [DW-1:0] c_q = '0;

  logic          ack0, ack1, c_wr;
  logic [DW-1:0] rdata0, rdata1, c_data;
  logic [AW-1:0] c_addr;
  logic [15:0]   rd_cnt, miss_cnt;

  logic          b_ack0, b_ack1, b_c_wr;
  logic [DW-1:0] b_rdata0, b_rdata1, b_c_data;
  logic [AW-1:0] b_c_addr;
  logic [1:0]    b_rd_cnt, b_miss_cnt;

  always #5 clk = ~clk;

  cache_arbiter #(.AW(AW), .DW(DW), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(t_req[0]), .wr0(t_wr[0]), .addr0(t_addr[0]), .wdata0(t_wd[0]),
    .ack0(ack0), .rdata0(rdata0),
    .req1(t_req[1]), .wr1(t_wr[1]), .addr1(t_addr[1]), .wdata1(t_wd[1]),
    .ack1(ack1), .rdata1(rdata1),
    .c_data(c_data), .c_addr(c_addr), .c_wr(c_wr),
    .c_state(c_state), .c_missrate(c_missrate), .c_q(c_q),
    .rd_cnt(rd_cnt), .miss_cnt(miss_cnt)
  );

  cache_arbiter #(.AW(AW), .DW(DW), .CW(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req0(t_req[0]), .wr0(t_wr[0]), .addr0(t_addr[0]), .wdata0(t_wd[0]),
    .ack0(b_ack0), .rdata0(b_rdata0),
    .req1(t_req[1]), .wr1(t_wr[1]), .addr1(t_addr[1]), .wdata1(t_wd[1]),
    .ack1(b_ack1), .rdata1(b_rdata1),
    .c_data(b_c_data), .c_addr(b_c_addr), .c_wr(b_c_wr),
    .c_state(c_state), .c_missrate(c_missrate), .c_q(c_q),
    .rd_cnt(b_rd_cnt), .miss_cnt(b_miss_cnt)
  );

  // Reference model state
  int            checks = 0;
  int            errors = 0;
  int            lastg;
  logic [DW-1:0] exp_rd [2];
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic          e_wr;
  int            n_rd, n_miss;

  function automatic int sat(input int n, input int cw);
    int mx;
    mx = (1 << cw) - 1;
    return (n > mx) ? mx : n;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    lastg     = 1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    e_addr    = '0;
    e_data    = '0;
    e_wr      = 1'b0;
    n_rd      = 0;
    n_miss    = 0;
  endtask

  task automatic check_outputs(input logic ea0, input logic ea1);
    chk("ack0", ack0, ea0);
    chk("ack1", ack1, ea1);
    chk("rdata0", rdata0, exp_rd[0]);
    chk("rdata1", rdata1, exp_rd[1]);
    chk("c_addr", c_addr, e_addr);
    chk("c_data", c_data, e_data);
    chk("c_wr", c_wr, e_wr);
    chk("rd_cnt", rd_cnt, sat(n_rd, 16));
    chk("miss_cnt", miss_cnt, sat(n_miss, 16));
    chk("sat_ack0", b_ack0, ea0);
    chk("sat_ack1", b_ack1, ea1);
    chk("sat_rdata0", b_rdata0, exp_rd[0]);
    chk("sat_rdata1", b_rdata1, exp_rd[1]);
    chk("sat_c_addr", b_c_addr, e_addr);
    chk("sat_c_data", b_c_data, e_data);
    chk("sat_c_wr", b_c_wr, e_wr);
    chk("sat_rd_cnt", b_rd_cnt, sat(n_rd, 2));
    chk("sat_miss_cnt", b_miss_cnt, sat(n_miss, 2));
  endtask

  // One transaction from the current IDLE cycle; the cache reports busy for
  // d WAIT cycles and then done, so the ack lands d+3 cycles after sampling.
  task automatic do_txn(input int d, input logic miss, input logic [DW-1:0] q, output int w);
    if (t_req[0] && t_req[1]) w = (lastg == 0) ? 1 : 0;
    else                      w = t_req[1] ? 1 : 0;
    lastg = w;
    step();
    e_addr = t_addr[w];
    e_data = t_wd[w];
    e_wr   = t_wr[w];
    check_outputs(1'b0, 1'b0);
    c_state    = 1'b1;
    c_q        = $urandom;
    c_missrate = 1'($urandom_range(0, 1));
    step();
    check_outputs(1'b0, 1'b0);
    for (int j = 0; j <= d; j++) begin
      if (j == d) begin
        c_state    = 1'b1;
        c_q        = q;
        c_missrate = miss;
      end else begin
        c_state    = 1'b0;
        c_q        = $urandom;
        c_missrate = 1'($urandom_range(0, 1));
      end
      step();
      if (j < d) check_outputs(1'b0, 1'b0);
    end
    if (!t_wr[w]) begin
      exp_rd[w] = q;
      n_rd++;
      if (miss) n_miss++;
    end
    check_outputs(w == 0, w == 1);
    c_missrate = 1'b0;
  endtask

  task automatic set_req(input int r, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    t_req[r]  = 1'b1;
    t_wr[r]   = wr;
    t_addr[r] = a;
    t_wd[r]   = wd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, pw;
    logic [DW-1:0] q;
    t_addr[0] = '0; t_addr[1] = '0;
    t_wd[0]   = '0; t_wd[1]   = '0;

    // Reset state
    model_reset();
    rst_n = 1'b0;
    step(); step();
    check_outputs(1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    check_outputs(1'b0, 1'b0);

    // Read with two busy WAIT cycles: ack five cycles after sampling
    set_req(0, 1'b0, 32'h10, 32'h0);
    q = 32'hCAFE_0010;
    do_txn(2, 1'b0, q, w);
    chk("first_winner", w, 0);
    // Same read again: cache stays done, minimum latency, same data
    do_txn(0, 1'b0, q, w);
    chk("repeat_winner", w, 0);
    t_req[0] = 1'b0;
    step();
    check_outputs(1'b0, 1'b0);

    // Both requesters held: grants alternate
    set_req(0, 1'b0, 32'h20, 32'h0);
    set_req(1, 1'b0, 32'h24, 32'h0);
    pw = -1;
    for (int k = 0; k < 4; k++) begin
      do_txn(k % 2, 1'(k), $urandom, w);
      if (pw >= 0) chk("alternate", w, 1 - pw);
      pw = w;
    end
    t_req = '0;
    step();
    check_outputs(1'b0, 1'b0);

    // Write from requester 1: counters untouched
    set_req(1, 1'b1, 32'h4, 32'hDEAD_BEEF);
    do_txn(1, 1'b1, $urandom, w);
    chk("write_winner", w, 1);
    t_req[1] = 1'b0;
    step();
    check_outputs(1'b0, 1'b0);

    // Statistics: 5 reads, 3 misses, from a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    check_outputs(1'b0, 1'b0);
    set_req(0, 1'b0, 32'h30, 32'h0);
    for (int k = 0; k < 5; k++) do_txn(k % 3, 1'((k % 2) == 0), $urandom, w);
    t_req[0] = 1'b0;
    chk("rd_cnt_5", rd_cnt, 5);
    chk("miss_cnt_3", miss_cnt, 3);
    chk("rd_cnt_sat", b_rd_cnt, 3);
    step();
    check_outputs(1'b0, 1'b0);

    // Reset while in WAIT; the later cache completion must be ignored
    set_req(0, 1'b0, 32'h40, 32'h0);
    step();
    c_state = 1'b1;
    step();
    c_state = 1'b0;
    rst_n = 1'b0;
    t_req[0] = 1'b0;
    step();
    rst_n = 1'b1;
    c_state = 1'b1;
    c_q = 32'h1234_5678;
    c_missrate = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      check_outputs(1'b0, 1'b0);
      step();
    end
    c_missrate = 1'b0;
    set_req(0, 1'b0, 32'h44, 32'h0);
    do_txn(1, 1'b0, 32'h5555_AAAA, w);
    chk("post_reset_winner", w, 0);
    t_req[0] = 1'b0;
    step();
    check_outputs(1'b0, 1'b0);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      for (int r = 0; r < 2; r++) begin
        if (!t_req[r] && ($urandom_range(0, 1) == 1))
          set_req(r, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15) * 4), $urandom);
      end
      if (t_req == 2'b00) begin
        step();
        check_outputs(1'b0, 1'b0);
      end else begin
        do_txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom, w);
        if ($urandom_range(0, 1) == 1) t_req[w] = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
